// File: rtl/fifo_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ptr_ctrl
//   Read-side pointer controller of a dual-clock FIFO, fully in the read clock
//   domain. The grey-coded write pointer is synchronized, converted to binary
//   and registered. Empty, fill level and the RAM read strobe are derived from
//   it. The read pointer goes back to the write domain as registered grey code.
//
// Ports
//   clk          read-domain clock
//   rst_n        synchronous active-low reset
//   wr_ptr_grey  write pointer, grey code, asynchronous to clk
//   rd_req       pop request from the consumer
//   err_clr      clears the sticky error flags
//   ram_rd_en    RAM read strobe (rd_req & ~empty)
//   ram_rd_addr  RAM read address (low bits of the binary read pointer)
//   rd_data_vld  RAM data valid, ram_rd_en delayed one cycle
//   rd_ptr_grey  registered grey read pointer for the write domain
//   level        entries available, 0..2**ADDR_WIDTH
//   empty        level == 0
//   underflow    sticky: pop requested while empty
//   ptr_err      sticky: level exceeded the FIFO depth
// -----------------------------------------------------------------------------
module fifo_rd_ptr_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_grey,
  input  logic                  rd_req,
  input  logic                  err_clr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  rd_data_vld,
  output logic [ADDR_WIDTH:0]   rd_ptr_grey,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  underflow,
  output logic                  ptr_err
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  function automatic logic [PW-1:0] grey2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2grey(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wr_ptr_bin_q;
  logic [PW-1:0] rd_ptr_bin_q, rd_ptr_bin_d;
  logic [PW-1:0] rd_ptr_grey_q;
  logic          rd_data_vld_q;
  logic          underflow_q, underflow_d;
  logic          ptr_err_q, ptr_err_d;

  // Stage boundary: write-pointer synchronizer, plain flop chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wr_ptr_grey;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Stage boundary: binary write pointer registered after grey decode
  always_ff @(posedge clk) begin
    if (!rst_n) wr_ptr_bin_q <= '0;
    else        wr_ptr_bin_q <= grey2bin(sync_q[SYNC_STAGES-1]);
  end

  // Modulo subtraction keeps level correct across pointer wrap.
  assign level       = wr_ptr_bin_q - rd_ptr_bin_q;
  assign empty       = (level == '0);
  assign ram_rd_en   = rd_req & ~empty;
  assign ram_rd_addr = rd_ptr_bin_q[ADDR_WIDTH-1:0];

  always_comb begin
    rd_ptr_bin_d = rd_ptr_bin_q + {{ADDR_WIDTH{1'b0}}, ram_rd_en};
    // Set condition takes priority over err_clr.
    underflow_d  = (rd_req & empty) | (underflow_q & ~err_clr);
    ptr_err_d    = (level > DEPTH)  | (ptr_err_q   & ~err_clr);
  end

  // Stage boundary: read pointer, data valid and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_bin_q  <= '0;
      rd_ptr_grey_q <= '0;
      rd_data_vld_q <= 1'b0;
      underflow_q   <= 1'b0;
      ptr_err_q     <= 1'b0;
    end else begin
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      // Grey taken from the next binary value so it changes with the pointer.
      rd_ptr_grey_q <= bin2grey(rd_ptr_bin_d);
      rd_data_vld_q <= ram_rd_en;
      underflow_q   <= underflow_d;
      ptr_err_q     <= ptr_err_d;
    end
  end

  assign rd_ptr_grey = rd_ptr_grey_q;
  assign rd_data_vld = rd_data_vld_q;
  assign underflow   = underflow_q;
  assign ptr_err     = ptr_err_q;

endmodule
